// File: rtl/game_pkg.sv
// Shared types for the math-game score logic: BCD digit type, digit maximum
// and the score counter state encoding.
package game_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } score_state_t;

endpackage

// File: rtl/bcd_count_digit.sv
// One combinational BCD digit stage with carry (and, under SCORE_PENALTY_EN,
// borrow); the top chains these and registers the result.
module bcd_count_digit
  import game_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       inc,
  input  logic       carry_in,
`ifdef SCORE_PENALTY_EN
  input  logic       dec,
  input  logic       borrow_in,
  output logic       borrow_out,
`endif
  output logic [3:0] digit_out,
  output logic       carry_out
);

  always_comb begin
    digit_out = digit_in;
    carry_out = 1'b0;
`ifdef SCORE_PENALTY_EN
    borrow_out = 1'b0;
`endif
    if (inc && carry_in) begin
      if (digit_in >= BCD_MAX) begin
        digit_out = 4'd0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end
`ifdef SCORE_PENALTY_EN
    else if (dec && borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
`endif
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Round-gated multi-digit BCD score counter with saturate/wrap overflow.
// Optional wrong-answer penalty (BCD decrement, floored at 0): SCORE_PENALTY_EN.
module score_bcd_counter
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    correct,
  input  logic                    wrong,
  input  logic                    time_out,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    running,
  output logic                    frozen,
  output logic [1:0]              dbg_state
);

  localparam int W = 4 * NUM_DIGITS;

  score_state_t      r_state, w_state_nxt;
  logic [W-1:0]      r_score, w_score_nxt, w_score_step;
  logic              r_carry_out, w_carry_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_running, r_frozen;
  logic              w_do_inc;
  logic [NUM_DIGITS:0] w_carry;

  // Correct and wrong in the same cycle cancel out, so neither counts.
  assign w_do_inc   = (r_state == RUN) && correct && !wrong;
  assign w_carry[0] = 1'b1;

`ifdef SCORE_PENALTY_EN
  logic                w_do_dec;
  logic [NUM_DIGITS:0] w_borrow;
  assign w_do_dec    = (r_state == RUN) && wrong && !correct;
  assign w_borrow[0] = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_count_digit u_digit (
      .digit_in  (r_score[4*gi +: 4]),
      .inc       (w_do_inc),
      .carry_in  (w_carry[gi]),
`ifdef SCORE_PENALTY_EN
      .dec       (w_do_dec),
      .borrow_in (w_borrow[gi]),
      .borrow_out(w_borrow[gi+1]),
`endif
      .digit_out (w_score_step[4*gi +: 4]),
      .carry_out (w_carry[gi+1])
    );
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_score_nxt    = r_score;
    w_overflow_nxt = r_overflow;
    w_carry_nxt    = 1'b0;
    if (clear) begin
      w_state_nxt    = IDLE;
      w_score_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE, FROZEN: begin
          if (start) begin
            w_state_nxt    = RUN;
            w_score_nxt    = '0;
            w_overflow_nxt = 1'b0;
          end
        end
        RUN: begin
          if (w_do_inc) begin
            w_score_nxt = w_score_step;
            // Carry out of the top digit means the score was already all 9s.
            if (w_carry[NUM_DIGITS]) begin
              w_carry_nxt    = 1'b1;
              w_overflow_nxt = 1'b1;
              if (SATURATE) w_score_nxt = r_score;
            end
          end
`ifdef SCORE_PENALTY_EN
          else if (w_do_dec && !w_borrow[NUM_DIGITS]) begin
            w_score_nxt = w_score_step;
          end
`endif
          if (time_out) w_state_nxt = FROZEN;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_score     <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_running   <= 1'b0;
      r_frozen    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_carry_out <= w_carry_nxt;
      r_overflow  <= w_overflow_nxt;
      r_running   <= (w_state_nxt == RUN);
      r_frozen    <= (w_state_nxt == FROZEN);
    end
  end

  assign score     = r_score;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign running   = r_running;
  assign frozen    = r_frozen;
  assign dbg_state = r_state;

endmodule
